// File: rtl/snake_sub_arbiter_if.sv
// snake_sub_arbiter_if: request and response bundle of the shared 5-bit subtractor.
// The master modport is the requester/consumer side; the slave modport is the arbiter.
// Both channels use valid/ready. A transfer happens on a rising edge where valid and
// ready are both high. The source holds valid and its payload stable until that edge.
// It may withdraw a request before it is granted; the request is then not performed.
interface snake_sub_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_diff;
  logic                     rsp_borrow;
  logic                     rsp_zero;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_diff, rsp_borrow, rsp_zero
  );
endinterface

// File: rtl/snake_sub_arbiter.sv
// snake_sub_arbiter: round-robin sharing of one A + ~B + 1 subtract unit.
// Flow is IDLE (grant) -> CALC (subtract) -> DONE (hold the response until it is accepted).
// Optional macro SNAKE_SUB_ABS_EN makes the unit return |A - B|.
// In that mode the operands are swapped when A < B; rsp_borrow still reports A < B.
module snake_sub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  snake_sub_arbiter_if.slave   bus,
  output logic [1:0]           dbg_state
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic [IDW:0]     rr_sum;
  logic [IDW-1:0]   rr_idx;
  logic [WIDTH-1:0] op_a, op_b;
  logic [IDW-1:0]   op_id;
  logic             sub_swap;
  logic [WIDTH-1:0] sub_x, sub_y;
  logic [WIDTH:0]   sub_sum;
  logic             calc_borrow;

  // Round-robin search: the first valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_sum      = '0;
    rr_idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum = {1'b0, ptr} + (IDW+1)'(k);
      rr_idx = (rr_sum >= (IDW+1)'(NUM_REQ)) ? IDW'(rr_sum - (IDW+1)'(NUM_REQ)) : IDW'(rr_sum);
      if (!grant_found && bus.req_valid[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and grant. req_ready is never driven while reset is high.
  always_comb begin
    state_next    = state;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          state_next = CALC;
          if (!reset) bus.req_ready[grant_idx] = 1'b1;
        end
      end
      CALC:    state_next = DONE;
      DONE:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the winner's operands and advance the round-robin pointer past it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_id <= '0;
    end else if (state == IDLE && grant_found) begin
      op_a  <= bus.req_a[grant_idx*WIDTH +: WIDTH];
      op_b  <= bus.req_b[grant_idx*WIDTH +: WIDTH];
      op_id <= grant_idx;
      ptr   <= (grant_idx == IDW'(NUM_REQ-1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  // The single subtract unit. The carry-out is the inverted borrow.
  // In absolute mode the operands are swapped, so the carry is always set.
  // The borrow then comes from the swap decision.
  always_comb begin
`ifdef SNAKE_SUB_ABS_EN
    sub_swap = (op_a < op_b);
`else
    sub_swap = 1'b0;
`endif
    sub_x       = sub_swap ? op_b : op_a;
    sub_y       = sub_swap ? op_a : op_b;
    sub_sum     = {1'b0, sub_x} + {1'b0, ~sub_y} + (WIDTH+1)'(1);
    calc_borrow = sub_swap | ~sub_sum[WIDTH];
  end

  // Response registers: loaded in CALC and held through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rsp_id     <= '0;
      bus.rsp_diff   <= '0;
      bus.rsp_borrow <= 1'b0;
      bus.rsp_zero   <= 1'b0;
    end else if (state == CALC) begin
      bus.rsp_id     <= op_id;
      bus.rsp_diff   <= sub_sum[WIDTH-1:0];
      bus.rsp_borrow <= calc_borrow;
      bus.rsp_zero   <= (sub_sum[WIDTH-1:0] == '0);
    end
  end

  assign bus.rsp_valid = (state == DONE);
  assign dbg_state     = state;
endmodule

// File: tb/tb_snake_sub_arbiter.sv
// tb_snake_sub_arbiter: table vectors, hand-written corner sequences and a random phase.
// The random phase is scored against a transaction-level model.
module tb_snake_sub_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 5;
  localparam int IDW     = $clog2(NUM_REQ);
  localparam int RSP_W   = IDW + 2 + WIDTH;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  snake_sub_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus();

  snake_sub_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [RSP_W-1:0] exp_q[$];

  typedef struct {
    int id;
    int a;
    int b;
    int diff;
    bit borrow;
    bit zero;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input int a, input int b);
    logic [WIDTH-1:0] aw, bw;
    aw = a[WIDTH-1:0];
    bw = b[WIDTH-1:0];
    bus.req_valid[i]                = v;
    bus.req_a[i*WIDTH +: WIDTH]     = aw;
    bus.req_b[i*WIDTH +: WIDTH]     = bw;
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // Expected response, packed as {id, borrow, zero, diff}, straight from the arithmetic.
  function automatic logic [RSP_W-1:0] exp_rsp(input int a, input int b, input int id);
    int d;
    logic [WIDTH-1:0] dw;
    logic [IDW-1:0] iw;
    logic lt, eq;
`ifdef SNAKE_SUB_ABS_EN
    d = (a < b) ? (b - a) : (a - b);
`else
    d = (a - b + (1 << WIDTH)) % (1 << WIDTH);
`endif
    dw = d[WIDTH-1:0];
    iw = id[IDW-1:0];
    lt = (a < b);
    eq = (a == b);
    return {iw, lt, eq, dw};
  endfunction

  function automatic logic [RSP_W-1:0] act_rsp();
    return {bus.rsp_id, bus.rsp_borrow, bus.rsp_zero, bus.rsp_diff};
  endfunction

  initial begin
    logic [RSP_W-1:0] tv;
    logic [IDW-1:0] tid;
    logic [WIDTH-1:0] td;
    logic [NUM_REQ-1:0] exp_ready;
    int phase, m_ptr, win;
    bit pend[NUM_REQ];
    int pa[NUM_REQ];
    int pb[NUM_REQ];

    // Vector table: {requester, a, b, diff, borrow, zero}.
    tbl[0] = '{0, 9, 3, 6, 1'b0, 1'b0};
`ifdef SNAKE_SUB_ABS_EN
    tbl[1] = '{2, 3, 9, 6, 1'b1, 1'b0};
    tbl[4] = '{0, 0, 31, 31, 1'b1, 1'b0};
    tbl[5] = '{3, 16, 17, 1, 1'b1, 1'b0};
`else
    tbl[1] = '{2, 3, 9, 26, 1'b1, 1'b0};
    tbl[4] = '{0, 0, 31, 1, 1'b1, 1'b0};
    tbl[5] = '{3, 16, 17, 31, 1'b1, 1'b0};
`endif
    tbl[2] = '{1, 17, 17, 0, 1'b0, 1'b1};
    tbl[3] = '{3, 31, 0, 31, 1'b0, 1'b0};
    tbl[6] = '{1, 0, 0, 0, 1'b0, 1'b1};

    // Reset, with every requester valid: no grant may appear while reset is high.
    reset = 1'b1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, i, 0);
    step();
    #1;
    check("reset_ready", 32'(bus.req_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp", 32'(act_rsp()), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    bus.req_valid = '0;
    step();

    // Single-request vectors: grant now, CALC next cycle, response in the cycle after.
    for (int v = 0; v < 7; v++) begin
      set_req(tbl[v].id, 1'b1, tbl[v].a, tbl[v].b);
      bus.rsp_ready = 1'b1;
      #1;
      check("tbl_grant", 32'(bus.req_ready), 32'(onehot(tbl[v].id)));
      step();
      bus.req_valid = '0;
      #1;
      check("tbl_calc", 32'({bus.req_ready, bus.rsp_valid}), 32'd0);
      step();
      #1;
      tid = tbl[v].id[IDW-1:0];
      td  = tbl[v].diff[WIDTH-1:0];
      check("tbl_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("tbl_rsp", 32'(act_rsp()), 32'({tid, tbl[v].borrow, tbl[v].zero, td}));
      step();
      #1;
      check("tbl_idle", 32'(bus.rsp_valid), 32'd0);
    end

    // All requesters held valid from reset: grants and response ids go 0,1,2,3,0.
    step();
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 20, i);
    #1;
    check("rr_ready_in_reset", 32'(bus.req_ready), 32'd0);
    step();
    reset = 1'b0;
    for (int g = 0; g < 5; g++) begin
      #1;
      check("rr_grant", 32'(bus.req_ready), 32'(onehot(g % NUM_REQ)));
      step();
      #1;
      check("rr_calc", 32'({bus.req_ready, bus.rsp_valid}), 32'd0);
      step();
      #1;
      check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("rr_rsp", 32'(act_rsp()), 32'(exp_rsp(20, g % NUM_REQ, g % NUM_REQ)));
      step();
    end

    // Backpressure: requester 0 in flight, requester 1 pending, rsp_ready low for 5 DONE cycles.
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 4, 11);
    #1;
    check("bp_grant0", 32'(bus.req_ready), 32'(onehot(0)));
    step();
    set_req(0, 1'b0, 4, 11);
    set_req(1, 1'b1, 20, 5);
    #1;
    check("bp_calc", 32'({bus.req_ready, bus.rsp_valid}), 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_hold_ctl", 32'({bus.req_ready, bus.rsp_valid}), 32'd1);
      check("bp_hold_rsp", 32'(act_rsp()), 32'(exp_rsp(4, 11, 0)));
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_release", 32'({bus.req_ready, bus.rsp_valid}), 32'd1);
    step();
    #1;
    check("bp_grant1", 32'(bus.req_ready), 32'(onehot(1)));
    step();
    set_req(1, 1'b0, 20, 5);
    step();
    #1;
    check("bp_rsp1", 32'(act_rsp()), 32'(exp_rsp(20, 5, 1)));
    step();

    // Reset while requester 3 is in CALC: the operation vanishes and ptr restarts at 0.
    set_req(3, 1'b1, 7, 2);
    #1;
    check("rst_grant3", 32'(bus.req_ready), 32'(onehot(3)));
    step();
    set_req(3, 1'b0, 7, 2);
    reset = 1'b1;
    #1;
    check("rst_calc_ready", 32'(bus.req_ready), 32'd0);
    step();
    reset = 1'b0;
    set_req(1, 1'b1, 6, 6);
    set_req(3, 1'b1, 7, 2);
    #1;
    check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_vals", 32'(act_rsp()), 32'd0);
    check("rst_grant1_first", 32'(bus.req_ready), 32'(onehot(1)));
    step();
    set_req(1, 1'b0, 6, 6);
    step();
    #1;
    check("rst_rsp1", 32'(act_rsp()), 32'(exp_rsp(6, 6, 1)));
    step();
    #1;
    check("rst_grant3_next", 32'(bus.req_ready), 32'(onehot(3)));
    step();
    set_req(3, 1'b0, 7, 2);
    step();
    #1;
    check("rst_rsp3", 32'(act_rsp()), 32'(exp_rsp(7, 2, 3)));
    step();

    // Random traffic scored against a transaction-level model.
    reset = 1'b1;
    bus.req_valid = '0;
    step();
    reset = 1'b0;
    phase = 0;
    m_ptr = 0;
    exp_q.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0;
      pa[i] = 0;
      pb[i] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = $urandom_range(0, 31);
          pb[i] = ($urandom_range(0, 4) == 0) ? pa[i] : $urandom_range(0, 31);
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
        set_req(i, pend[i], pa[i], pb[i]);
      end
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      win = -1;
      exp_ready = '0;
      if (phase == 0) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (win < 0 && pend[(m_ptr + k) % NUM_REQ]) win = (m_ptr + k) % NUM_REQ;
        end
        if (win >= 0) exp_ready = onehot(win);
      end
      check("rnd_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(phase == 2));
      if (phase == 2) begin
        if (exp_q.size() == 0) begin
          tv = '0;
        end else begin
          tv = exp_q[0];
        end
        check("rnd_rsp", 32'(act_rsp()), 32'(tv));
      end
      if (phase == 0 && win >= 0) begin
        exp_q.push_back(exp_rsp(pa[win], pb[win], win));
        m_ptr = (win + 1) % NUM_REQ;
        pend[win] = 1'b0;
        phase = 1;
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2 && bus.rsp_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        phase = 0;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
